// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control slice: FSM states,
// opcode/funct values, ALU operation codes and datapath mux selects.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_RST       = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_mc_aludec.sv
// ALU decoder: funct -> R-type ALU op with a valid flag, and opcode ->
// I-type ALU op with the extender mode that immediate form needs.
module mips_mc_aludec
  import mips_mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] r_alu_op,
  output logic       r_valid,
  output logic [3:0] i_alu_op,
  output logic       i_ext_op
);

  always_comb begin
    r_alu_op = ALU_ADD;
    r_valid  = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: r_alu_op = ALU_ADD;
      FN_SUB, FN_SUBU: r_alu_op = ALU_SUB;
      FN_AND:          r_alu_op = ALU_AND;
      FN_OR:           r_alu_op = ALU_OR;
      FN_XOR:          r_alu_op = ALU_XOR;
      FN_NOR:          r_alu_op = ALU_NOR;
      FN_SLT:          r_alu_op = ALU_SLT;
      FN_SLTU:         r_alu_op = ALU_SLTU;
      default:         r_valid  = 1'b0;
    endcase
  end

  // Arithmetic/compare immediates are signed; logical ones and lui are not.
  always_comb begin
    i_alu_op = ALU_ADD;
    i_ext_op = 1'b0;
    case (opcode)
      OP_ADDI, OP_ADDIU: begin
        i_alu_op = ALU_ADD;
        i_ext_op = 1'b1;
      end
      OP_SLTI: begin
        i_alu_op = ALU_SLT;
        i_ext_op = 1'b1;
      end
      OP_SLTIU: begin
        i_alu_op = ALU_SLTU;
        i_ext_op = 1'b1;
      end
      OP_ANDI: i_alu_op = ALU_AND;
      OP_ORI:  i_alu_op = ALU_OR;
      OP_XORI: i_alu_op = ALU_XOR;
      OP_LUI:  i_alu_op = ALU_LUI;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main control FSM with memory-timeout and illegal-op traps.
// Optional retired-instruction counter enabled by `define MIPS_MC_INSTRET_EN.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        ext_op,
  output logic        illegal,
  output logic        timeout,
  output logic [31:0] instret
);

  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;
  logic       in_mem;

  logic [3:0] r_alu_op, i_alu_op;
  logic       r_valid, i_ext_op;

  mips_mc_aludec u_aludec (
    .opcode   (opcode),
    .funct    (funct),
    .r_alu_op (r_alu_op),
    .r_valid  (r_valid),
    .i_alu_op (i_alu_op),
    .i_ext_op (i_ext_op)
  );

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    ext_op     = 1'b0;
    in_mem     = 1'b0;
    state_d    = state_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    wait_d     = 8'd0;

    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        in_mem    = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_src  = PCSRC_ALU;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        ext_op    = 1'b1;
        case (opcode)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
          OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_I_EXEC;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b1;
        state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        in_mem  = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        in_mem  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = r_alu_op;
        if (r_valid) begin
          state_d = S_R_WB;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_R_WB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        state_d = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = i_alu_op;
        ext_op    = i_ext_op;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_we     = (opcode == OP_BNE) ? ~zero : zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_we   = 1'b1;
        pc_src  = PCSRC_JUMP;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_RST;
    endcase

    // A ready in the same cycle the limit is reached wins over the trap.
    if (in_mem && !mem_ready) begin
      if (({1'b0, wait_q} + 9'd1) >= TIMEOUT_LIM) begin
        state_d   = S_TRAP;
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;

`ifdef MIPS_MC_INSTRET_EN
  logic [31:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_RST)
      instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= 32'd0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: builds per-instruction expected control-word
// sequences from the instruction semantics and compares them cycle by cycle.
module tb_mips_mc_ctrl;

  localparam int TMO = 4;
`ifdef MIPS_MC_INSTRET_EN
  localparam bit INSTRET_ON = 1'b1;
`else
  localparam bit INSTRET_ON = 1'b0;
`endif

  logic        clk, rst_n;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0]  pc_src;
  logic        reg_we, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_op;
  logic        ext_op, illegal, timeout;
  logic [31:0] instret;

  mips_mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_op(ext_op),
    .illegal(illegal), .timeout(timeout), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       ext_op;
  } ctl_t;

  typedef struct {
    logic rdy;
    ctl_t c;
    logic ill;
    logic tmo;
  } step_t;

  ctl_t obs;
  assign obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op};

  step_t      q[$];
  int         checks = 0;
  int         errors = 0;
  int         retired = 0;
  logic       exp_ill = 1'b0;
  logic       exp_tmo = 1'b0;
  logic [5:0] nx_op = 6'h00;
  logic [5:0] nx_fn = 6'h00;
  logic       nx_zero = 1'b0;
  logic [5:0] vf[10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                         6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // R-type funct -> ALU op (unknown funct leaves the ALU on add).
  function automatic logic [3:0] r_op(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return 4'd0;
      6'h22, 6'h23: return 4'd1;
      6'h24: return 4'd2;
      6'h25: return 4'd3;
      6'h26: return 4'd4;
      6'h27: return 4'd5;
      6'h2A: return 4'd6;
      6'h2B: return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] i_op(input logic [5:0] op);
    case (op)
      6'h08, 6'h09: return 4'd0;
      6'h0A: return 4'd6;
      6'h0B: return 4'd7;
      6'h0C: return 4'd2;
      6'h0D: return 4'd3;
      6'h0E: return 4'd4;
      6'h0F: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic push(input logic r, input ctl_t c);
    step_t s;
    s.rdy = r;
    s.c   = c;
    s.ill = exp_ill;
    s.tmo = exp_tmo;
    q.push_back(s);
  endtask

  task automatic b_fetch(input int w);
    ctl_t c;
    c = '0;
    c.mem_req = 1'b1;
    c.alu_src_b = 2'd1;
    repeat (w) push(1'b0, c);
    c.ir_we = 1'b1;
    c.pc_we = 1'b1;
    push(1'b1, c);
  endtask

  task automatic b_decode();
    ctl_t c;
    c = '0;
    c.alu_src_b = 2'd3;
    c.ext_op = 1'b1;
    push(rbit(), c);
  endtask

  task automatic b_memaddr();
    ctl_t c;
    c = '0;
    c.alu_src_a = 1'b1;
    c.alu_src_b = 2'd2;
    c.ext_op = 1'b1;
    push(rbit(), c);
  endtask

  task automatic b_mem(input logic we, input int w);
    ctl_t c;
    c = '0;
    c.mem_req = 1'b1;
    c.mem_we = we;
    c.iord = 1'b1;
    repeat (w) push(1'b0, c);
    push(1'b1, c);
  endtask

  task automatic b_trap(input int n);
    repeat (n) push(rbit(), '0);
  endtask

  task automatic run_q(input string tag);
    foreach (q[i]) begin
      @(negedge clk);
      if (i == 0) begin
        opcode = nx_op;
        funct  = nx_fn;
        zero   = nx_zero;
      end
      mem_ready = q[i].rdy;
      #1;
      check($sformatf("%s.ctl[%0d]", tag, i), 32'(obs), 32'(q[i].c));
      check($sformatf("%s.illegal[%0d]", tag, i), 32'(illegal), 32'(q[i].ill));
      check($sformatf("%s.timeout[%0d]", tag, i), 32'(timeout), 32'(q[i].tmo));
      check($sformatf("%s.instret[%0d]", tag, i), instret,
            INSTRET_ON ? 32'(retired) : 32'd0);
    end
    q.delete();
  endtask

  task automatic do_r(input logic [5:0] f, input int fw);
    ctl_t c;
    nx_op = 6'h00; nx_fn = f; nx_zero = rbit();
    b_fetch(fw);
    b_decode();
    c = '0; c.alu_src_a = 1'b1; c.alu_op = r_op(f);
    push(rbit(), c);
    c = '0; c.reg_we = 1'b1; c.reg_dst = 1'b1;
    push(rbit(), c);
    run_q($sformatf("r%02h", f));
    retired++;
  endtask

  task automatic do_i(input logic [5:0] op, input int fw);
    ctl_t c;
    nx_op = op; nx_fn = 6'($urandom); nx_zero = rbit();
    b_fetch(fw);
    b_decode();
    c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = i_op(op);
    c.ext_op = (op <= 6'h0B);
    push(rbit(), c);
    c = '0; c.reg_we = 1'b1;
    push(rbit(), c);
    run_q($sformatf("i%02h", op));
    retired++;
  endtask

  task automatic do_lw(input int fw, input int mw);
    ctl_t c;
    nx_op = 6'h23; nx_fn = 6'($urandom); nx_zero = rbit();
    b_fetch(fw);
    b_decode();
    b_memaddr();
    b_mem(1'b0, mw);
    c = '0; c.reg_we = 1'b1; c.mem_to_reg = 1'b1;
    push(rbit(), c);
    run_q("lw");
    retired++;
  endtask

  task automatic do_sw(input int fw, input int mw);
    nx_op = 6'h2B; nx_fn = 6'($urandom); nx_zero = rbit();
    b_fetch(fw);
    b_decode();
    b_memaddr();
    b_mem(1'b1, mw);
    run_q("sw");
    retired++;
  endtask

  task automatic do_br(input logic bne, input logic z, input int fw);
    ctl_t c;
    nx_op = bne ? 6'h05 : 6'h04; nx_fn = 6'($urandom); nx_zero = z;
    b_fetch(fw);
    b_decode();
    c = '0; c.alu_src_a = 1'b1; c.alu_op = 4'd1; c.pc_src = 2'd1;
    c.pc_we = bne ? ~z : z;
    push(rbit(), c);
    run_q(bne ? "bne" : "beq");
    retired++;
  endtask

  task automatic do_j(input int fw);
    ctl_t c;
    nx_op = 6'h02; nx_fn = 6'($urandom); nx_zero = rbit();
    b_fetch(fw);
    b_decode();
    c = '0; c.pc_we = 1'b1; c.pc_src = 2'd2;
    push(rbit(), c);
    run_q("j");
    retired++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst.ctl", 32'(obs), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    check("rst.timeout", 32'(timeout), 32'd0);
    check("rst.instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_state.ctl", 32'(obs), 32'd0);
    exp_ill = 1'b0;
    exp_tmo = 1'b0;
    retired = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t c;
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    do_i(6'h08, 0);
    do_lw(0, 3);
    do_br(1'b0, 1'b1, 0);
    do_br(1'b1, 1'b1, 0);
    do_i(6'h0D, 0);
    do_sw(0, 0);
    do_j(0);
    do_r(6'h20, 0);
    do_r(6'h2A, TMO - 1);

    for (int n = 0; n < 60; n++) begin
      int k, fw, mw;
      k  = $urandom_range(0, 6);
      fw = $urandom_range(0, TMO - 1);
      mw = $urandom_range(0, TMO - 1);
      case (k)
        0: do_r(vf[$urandom_range(0, 9)], fw);
        1: do_i(6'(8 + $urandom_range(0, 7)), fw);
        2: do_lw(fw, mw);
        3: do_sw(fw, mw);
        4: do_br(1'b0, rbit(), fw);
        5: do_br(1'b1, rbit(), fw);
        default: do_j(fw);
      endcase
    end

    // Unknown funct traps from R_EXEC.
    nx_op = 6'h00; nx_fn = 6'h3F; nx_zero = 1'b0;
    b_fetch(0);
    b_decode();
    c = '0; c.alu_src_a = 1'b1; c.alu_op = r_op(6'h3F);
    push(1'b0, c);
    exp_ill = 1'b1;
    b_trap(10);
    run_q("trap_funct");
    do_reset();
    do_i(6'h0C, 0);

    // Undecodable opcode traps from DECODE.
    nx_op = 6'h3F; nx_fn = 6'h00; nx_zero = 1'b0;
    b_fetch(1);
    b_decode();
    exp_ill = 1'b1;
    b_trap(10);
    run_q("trap_op");
    do_reset();

    // Memory never answers in FETCH.
    nx_op = 6'h08;
    c = '0; c.mem_req = 1'b1; c.alu_src_b = 2'd1;
    repeat (TMO) push(1'b0, c);
    exp_tmo = 1'b1;
    b_trap(6);
    run_q("tmo_fetch");
    do_reset();

    // Memory never answers in MEM_READ.
    nx_op = 6'h23;
    b_fetch(0);
    b_decode();
    b_memaddr();
    c = '0; c.mem_req = 1'b1; c.iord = 1'b1;
    repeat (TMO) push(1'b0, c);
    exp_tmo = 1'b1;
    b_trap(4);
    run_q("tmo_read");
    do_reset();

    // Reset in the middle of a stalled load.
    nx_op = 6'h23;
    b_fetch(0);
    b_decode();
    b_memaddr();
    c = '0; c.mem_req = 1'b1; c.iord = 1'b1;
    repeat (2) push(1'b0, c);
    run_q("lw_abort");
    do_reset();

    do_i(6'h0F, 0);
    do_sw(TMO - 1, TMO - 1);
    do_j(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle MIPS main control FSM; sequences the shared datapath (PC, IR, register file, immediate extender, ALU, memory port) one state per cycle.
- Drives extender mode `ext_op`: 1 = sign-extend, 0 = zero-extend.
- Handshakes with a variable-latency memory port.
- Detects illegal instructions and memory timeouts.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles waiting on mem_ready in a memory state before trapping; range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; stable outside FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU result-zero flag
- mem_ready  in  1  memory accepted/completed the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write request (with mem_req)
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  IR load
- pc_we  out  1  PC load
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- reg_we  out  1  register-file write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  0 = reg B, 1 = const 4, 2 = ext imm, 3 = ext imm<<2
- alu_op  out  4  ALU operation code (package)
- ext_op  out  1  extender mode
- illegal  out  1  sticky: undecodable opcode/funct
- timeout  out  1  sticky: memory timeout
- instret  out  32  retired-instruction count (optional feature)

Behaviour:
- Outputs are combinational from state; ir_we, pc_we and state advance in memory states also depend on mem_ready.
- Unlisted outputs are 0 in each state.
- Reset (async, any state, mid-access included): state = RST, wait counter = 0, illegal = timeout = 0. All outputs 0 in RST. RST -> FETCH next cycle.
- FETCH: mem_req, iord=0, src_a=0, src_b=1, ADD.
  - mem_ready=1: ir_we=1, pc_we=1, pc_src=0 that cycle -> DECODE.
  - Otherwise stay.
- DECODE: src_a=0, src_b=3, ADD, ext_op=1 (branch target into ALUOut). Dispatch on opcode:
  - 0x00 -> R_EXEC
  - 0x23/0x2B -> MEM_ADDR
  - 0x04/0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x08-0x0F -> I_EXEC
  - else -> TRAP with illegal=1
- MEM_ADDR: src_a=1, src_b=2, ADD, ext_op=1. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_req, iord=1. mem_ready -> MEM_WB.
- MEM_WB: reg_we, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WRITE: mem_req, mem_we, iord=1. mem_ready -> FETCH.
- R_EXEC: src_a=1, src_b=0, alu_op from funct.
  - Valid funct: 0x20-0x27, 0x2A, 0x2B.
  - Unknown funct -> TRAP with illegal=1; otherwise -> R_WB.
- R_WB: reg_we, reg_dst=1 -> FETCH.
- I_EXEC: src_a=1, src_b=2, alu_op from opcode -> I_WB.
  - ext_op=1 for addi/addiu/slti/sltiu; 0 for andi/ori/xori/lui.
- I_WB: reg_we, reg_dst=0 -> FETCH.
- BRANCH: src_a=1, src_b=0, SUB, pc_src=1.
  - pc_we = zero for beq (0x04), !zero for bne (0x05).
  - -> FETCH.
- JUMP: pc_we, pc_src=2 -> FETCH.
- TRAP: all enables 0, mem_req=0; exits only via reset.
- Wait counter (8 bit):
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle there with mem_ready=0.
  - Reaching MEM_TIMEOUT with mem_ready=0 -> TRAP with timeout=1.
  - mem_ready in the same cycle the counter reaches the limit wins: no trap.
- Latency (zero-wait memory): R/I-type 4 cycles, lw 5, sw 4, branch/jump 3.

Optional Feature:
- MIPS_MC_INSTRET_EN defined: instret increments by 1 on every transition into FETCH from a non-RST state. Wraps at 2^32. Reset to 0.
- MIPS_MC_INSTRET_EN undefined: instret tied to 0, no counter flops.

Decomposition:
- Package mips_mc_pkg:
  - state enum
  - opcode/funct localparams
  - alu_op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, LUI=8
  - alu_src_b and pc_src encodings
- Sub-module mips_mc_aludec: combinational funct/opcode -> alu_op + valid flag.

Test Plan:
- Zero-wait addi (0x08): FETCH, DECODE, I_EXEC (ext_op=1, src_b=2, ADD), I_WB (reg_we=1, reg_dst=0); back in FETCH on cycle 5; instret=1.
- lw with mem_ready low 3 cycles in MEM_READ -> mem_req held 4 cycles, iord=1; MEM_WB asserts mem_to_reg=1, reg_we=1.
- beq with zero=1 -> pc_we=1, pc_src=1; bne with zero=1 -> pc_we=0.
- ori (0x0D) -> ext_op=0 in I_EXEC, alu_op=OR.
- R-type funct 0x3F -> TRAP, illegal=1, all enables 0 for 10 cycles. rst_n pulse -> RST, then FETCH.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP with timeout=1 after 4 wait cycles.
- Same setup with mem_ready=1 on the 4th cycle -> DECODE, no trap.
